// File: rtl/recwind_monitor.sv
// recwind_monitor
//   Passive in-line observer of the user datapath. Words flow through a
//   small fallthrough FIFO unchanged. A parser watches each transfer at the
//   FIFO head and, for IPv4/TCP packets (IHL 5), captures the TCP advertised
//   receive window from word 7. Statistics are exposed on the register ring.
//
// Ports
//   clk, reset              clock, synchronous active-high reset
//   in_data/in_ctrl/in_wr   upstream word; in_rdy = FIFO not nearly full
//   out_data/out_ctrl/out_wr downstream word (FIFO head), out_rdy from sink
//   reg_*_in / reg_*_out    register ring, one registered stage
//
// Register map (offset = low REG_ADDR_WIDTH address bits, block selected by
// the upper address bits matching RECWIND_MONITOR_BLOCK_ADDR):
//   0 thresh (software, 16b, upper bits ignored on write, read as zero)
//   1 tcp_pkts   2 other_pkts   3 last_win   4 min_win   5 low_win_cnt
module recwind_monitor #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = DATA_WIDTH / 8,
  parameter int UDP_REG_SRC_WIDTH = 2,
  parameter int UDP_REG_ADDR_WIDTH = 23,
  parameter int REG_ADDR_WIDTH = 3,
  parameter logic [UDP_REG_ADDR_WIDTH-REG_ADDR_WIDTH-1:0] RECWIND_MONITOR_BLOCK_ADDR = 'h42
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_WIDTH-1:0]         in_data,
  input  logic [CTRL_WIDTH-1:0]         in_ctrl,
  input  logic                          in_wr,
  output logic                          in_rdy,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [CTRL_WIDTH-1:0]         out_ctrl,
  output logic                          out_wr,
  input  logic                          out_rdy,
  input  logic                          reg_req_in,
  input  logic                          reg_ack_in,
  input  logic                          reg_rd_wr_L_in,
  input  logic [UDP_REG_ADDR_WIDTH-1:0] reg_addr_in,
  input  logic [31:0]                   reg_data_in,
  input  logic [UDP_REG_SRC_WIDTH-1:0]  reg_src_in,
  output logic                          reg_req_out,
  output logic                          reg_ack_out,
  output logic                          reg_rd_wr_L_out,
  output logic [UDP_REG_ADDR_WIDTH-1:0] reg_addr_out,
  output logic [31:0]                   reg_data_out,
  output logic [UDP_REG_SRC_WIDTH-1:0]  reg_src_out
);

  localparam int WORD_W = DATA_WIDTH + CTRL_WIDTH;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // ---- stage p0: fallthrough FIFO, head drives the output directly ----
  logic [WORD_W-1:0] fifo_mem [4];
  logic [1:0]        wr_ptr, rd_ptr;
  logic [2:0]        fifo_cnt;
  logic              fifo_empty, fifo_wr, xfer;
  logic [WORD_W-1:0] fifo_head;

  assign fifo_empty = (fifo_cnt == 3'd0);
  assign in_rdy     = (fifo_cnt < 3'd3);
  assign xfer       = !fifo_empty && out_rdy;
  assign fifo_wr    = in_wr && ((fifo_cnt != 3'd4) || xfer);
  assign fifo_head  = fifo_mem[rd_ptr];
  assign out_data   = fifo_head[DATA_WIDTH-1:0];
  assign out_ctrl   = fifo_head[DATA_WIDTH +: CTRL_WIDTH];
  assign out_wr     = xfer;

  always_ff @(posedge clk) begin
    if (fifo_wr) fifo_mem[wr_ptr] <= {in_ctrl, in_data};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= 2'd0;
      rd_ptr   <= 2'd0;
      fifo_cnt <= 3'd0;
    end else begin
      if (fifo_wr) wr_ptr <= wr_ptr + 2'd1;
      if (xfer)    rd_ptr <= rd_ptr + 2'd1;
      case ({fifo_wr, xfer})
        2'b10:   fifo_cnt <= fifo_cnt + 3'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 3'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // ---- parser FSM, advances only on transfer cycles ----
  typedef enum logic [1:0] {CTRL_HDR, PARSE, SKIP} state_t;
  state_t     state, state_nxt;
  logic [2:0] cnt, cnt_nxt;
  logic       tcp_flag, tcp_nxt, upd_nxt, other_nxt;
  logic       hdr_ok, ctrl_eop;

  assign ctrl_eop = (out_ctrl != '0);
  assign hdr_ok   = (out_data[31:16] == 16'h0800) && (out_data[15:12] == 4'd4) &&
                    (out_data[11:8] == 4'd5);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= CTRL_HDR;
      cnt      <= 3'd1;
      tcp_flag <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      tcp_flag <= tcp_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    tcp_nxt   = tcp_flag;
    upd_nxt   = 1'b0;
    other_nxt = 1'b0;
    if (xfer) begin
      case (state)
        CTRL_HDR: begin
          if (!ctrl_eop) begin
            state_nxt = PARSE;
            cnt_nxt   = 3'd2;
            tcp_nxt   = 1'b0;
          end
        end
        PARSE: begin
          if (cnt == 3'd7) begin
            upd_nxt = 1'b1;
            if (ctrl_eop) begin
              state_nxt = CTRL_HDR;
              cnt_nxt   = 3'd1;
            end else begin
              state_nxt = SKIP;
              tcp_nxt   = 1'b1;
            end
          end else if (ctrl_eop) begin
            // packet ended before the window word
            other_nxt = 1'b1;
            state_nxt = CTRL_HDR;
            cnt_nxt   = 3'd1;
          end else if ((cnt == 3'd2) && !hdr_ok) begin
            state_nxt = SKIP;
          end else if ((cnt == 3'd3) && (out_data[7:0] != 8'd6)) begin
            state_nxt = SKIP;
          end else begin
            cnt_nxt = cnt + 3'd1;
          end
        end
        SKIP: begin
          if (ctrl_eop) begin
            other_nxt = !tcp_flag;
            state_nxt = CTRL_HDR;
            cnt_nxt   = 3'd1;
            tcp_nxt   = 1'b0;
          end
        end
        default: begin
          state_nxt = CTRL_HDR;
          cnt_nxt   = 3'd1;
        end
      endcase
    end
  end

  // ---- stage p1: captured window and event pulses ----
  logic        vld_p1, other_p1;
  logic [15:0] win_p1;
  logic [15:0] thresh, last_win, min_win;
  logic [31:0] tcp_pkts, other_pkts, low_win_cnt;

  always_ff @(posedge clk) begin
    if (upd_nxt) win_p1 <= out_data[63:48];
  end

  // ---- stage p2: statistics registers ----
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1      <= 1'b0;
      other_p1    <= 1'b0;
      tcp_pkts    <= 32'd0;
      other_pkts  <= 32'd0;
      low_win_cnt <= 32'd0;
      last_win    <= 16'd0;
      min_win     <= 16'hFFFF;
    end else begin
      vld_p1   <= upd_nxt;
      other_p1 <= other_nxt;
      if (vld_p1) begin
        tcp_pkts <= sat_inc(tcp_pkts);
        last_win <= win_p1;
        if (win_p1 < min_win) min_win <= win_p1;
        if (win_p1 <= thresh) low_win_cnt <= sat_inc(low_win_cnt);
      end
      if (other_p1) other_pkts <= sat_inc(other_pkts);
    end
  end

  // ---- register ring stage ----
  logic                      reg_hit;
  logic [REG_ADDR_WIDTH-1:0] reg_off;
  logic [31:0]               rd_val;

  assign reg_off = reg_addr_in[REG_ADDR_WIDTH-1:0];
  assign reg_hit = reg_req_in && !reg_ack_in &&
                   (reg_addr_in[UDP_REG_ADDR_WIDTH-1:REG_ADDR_WIDTH] == RECWIND_MONITOR_BLOCK_ADDR);

  always_comb begin
    rd_val = 32'd0;
    case (reg_off)
      REG_ADDR_WIDTH'(0): rd_val = {16'd0, thresh};
      REG_ADDR_WIDTH'(1): rd_val = tcp_pkts;
      REG_ADDR_WIDTH'(2): rd_val = other_pkts;
      REG_ADDR_WIDTH'(3): rd_val = {16'd0, last_win};
      REG_ADDR_WIDTH'(4): rd_val = {16'd0, min_win};
      REG_ADDR_WIDTH'(5): rd_val = low_win_cnt;
      default:            rd_val = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      reg_req_out <= 1'b0;
      reg_ack_out <= 1'b0;
      thresh      <= 16'd0;
    end else begin
      reg_req_out <= reg_req_in;
      reg_ack_out <= reg_ack_in || reg_hit;
      if (reg_hit && !reg_rd_wr_L_in && (reg_off == REG_ADDR_WIDTH'(0)))
        thresh <= reg_data_in[15:0];
    end
  end

  always_ff @(posedge clk) begin
    reg_rd_wr_L_out <= reg_rd_wr_L_in;
    reg_addr_out    <= reg_addr_in;
    reg_src_out     <= reg_src_in;
    reg_data_out    <= (reg_hit && reg_rd_wr_L_in) ? rd_val : reg_data_in;
  end

endmodule

// File: tb/tb_recwind_monitor.sv
module tb_recwind_monitor;

  localparam logic [19:0] TAG = 20'h00042;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] in_data, out_data;
  logic [7:0]  in_ctrl, out_ctrl;
  logic        in_wr, in_rdy, out_wr;
  logic        out_rdy = 1'b1;
  logic        reg_req_in, reg_ack_in, reg_rd_wr_L_in;
  logic [22:0] reg_addr_in, reg_addr_out;
  logic [31:0] reg_data_in, reg_data_out;
  logic [1:0]  reg_src_in, reg_src_out;
  logic        reg_req_out, reg_ack_out, reg_rd_wr_L_out;

  always #5 clk = ~clk;

  recwind_monitor dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_ctrl(in_ctrl), .in_wr(in_wr), .in_rdy(in_rdy),
    .out_data(out_data), .out_ctrl(out_ctrl), .out_wr(out_wr), .out_rdy(out_rdy),
    .reg_req_in(reg_req_in), .reg_ack_in(reg_ack_in), .reg_rd_wr_L_in(reg_rd_wr_L_in),
    .reg_addr_in(reg_addr_in), .reg_data_in(reg_data_in), .reg_src_in(reg_src_in),
    .reg_req_out(reg_req_out), .reg_ack_out(reg_ack_out), .reg_rd_wr_L_out(reg_rd_wr_L_out),
    .reg_addr_out(reg_addr_out), .reg_data_out(reg_data_out), .reg_src_out(reg_src_out)
  );

  int checks = 0;
  int errors = 0;
  logic [71:0] exp_q[$];
  logic [71:0] pkt[$];
  bit          mon_en = 1'b1;
  int          rdy_mode = 0;   // 0 always ready, 1 never ready, 2 random

  // reference model state
  bit          pkt_tcp;
  logic [15:0] pkt_win;
  logic [31:0] m_tcp, m_other, m_low;
  logic [15:0] m_last, m_min, m_thresh;

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_rdy = 1'b1;
      1:       out_rdy = 1'b0;
      default: out_rdy = 1'($urandom_range(0, 1));
    endcase
  end

  // every transferred word must be the next word sent, in order
  always @(negedge clk) begin
    if (mon_en && out_wr === 1'b1) begin
      if (exp_q.size() == 0) check("extra_word", 72'(exp_q.size()), 72'd1);
      else check("out_word", {out_ctrl, out_data}, exp_q.pop_front());
    end
  end

  task automatic model_reset();
    m_tcp = 0; m_other = 0; m_low = 0; m_last = 16'h0; m_min = 16'hFFFF; m_thresh = 16'h0;
  endtask

  // Packet: one module header word, then n data words, the n-th carrying eop.
  task automatic build_pkt(input logic [15:0] etype, input logic [3:0] ver, input logic [3:0] ihl,
                           input logic [7:0] proto, input logic [15:0] win, input int n,
                           input logic [7:0] eop);
    logic [63:0] d;
    pkt.delete();
    pkt.push_back({8'hFF, $urandom(), $urandom()});
    for (int i = 1; i <= n; i++) begin
      d = {$urandom(), $urandom()};
      if (i == 2) begin d[31:16] = etype; d[15:12] = ver; d[11:8] = ihl; end
      if (i == 3) d[7:0] = proto;
      if (i == 7) d[63:48] = win;
      pkt.push_back({(i == n) ? eop : 8'h00, d});
    end
    pkt_tcp = (n >= 7) && (etype == 16'h0800) && (ver == 4'd4) && (ihl == 4'd5) && (proto == 8'd6);
    pkt_win = win;
  endtask

  task automatic commit_pkt();
    foreach (pkt[i]) exp_q.push_back(pkt[i]);
    if (pkt_tcp) begin
      m_tcp++;
      m_last = pkt_win;
      if (pkt_win < m_min) m_min = pkt_win;
      if (pkt_win <= m_thresh) m_low++;
    end else begin
      m_other++;
    end
  endtask

  task automatic drive_range(input int s, input int e);
    int w;
    for (int i = s; i < e; i++) begin
      if (!in_rdy) begin
        in_wr = 1'b0;
        w = 0;
        while (!in_rdy && w < 1000) begin @(posedge clk); #1; w++; end
        if (w >= 1000) check("in_rdy_timeout", 72'(in_rdy), 72'd1);
      end
      {in_ctrl, in_data} = pkt[i];
      in_wr = 1'b1;
      @(posedge clk); #1;
    end
    in_wr = 1'b0;
  endtask

  task automatic send_pkt(input logic [15:0] etype, input logic [3:0] ver, input logic [3:0] ihl,
                          input logic [7:0] proto, input logic [15:0] win, input int n,
                          input logic [7:0] eop);
    build_pkt(etype, ver, ihl, proto, win, n, eop);
    commit_pkt();
    drive_range(0, pkt.size());
  endtask

  task automatic drain();
    int w = 0;
    while (exp_q.size() != 0 && w < 5000) begin @(posedge clk); #1; w++; end
    check("drain_left", 72'(exp_q.size()), 72'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic reg_access(input bit rd, input logic [19:0] tag, input logic [2:0] off,
                            input logic [31:0] wdata, output logic [31:0] rdata, output logic ack);
    int w = 0;
    reg_req_in = 1'b1; reg_rd_wr_L_in = rd; reg_addr_in = {tag, off};
    reg_data_in = wdata; reg_src_in = 2'b01;
    @(posedge clk); #1;
    reg_req_in = 1'b0;
    while (reg_req_out !== 1'b1 && w < 8) begin @(posedge clk); #1; w++; end
    rdata = reg_data_out;
    ack = reg_ack_out;
  endtask

  task automatic read_check(input string tag, input logic [2:0] off, input logic [31:0] expv);
    logic [31:0] d;
    logic a;
    reg_access(1'b1, TAG, off, 32'h0, d, a);
    check({tag, "_ack"}, 72'(a), 72'd1);
    check(tag, 72'(d), 72'(expv));
  endtask

  task automatic write_thresh(input logic [31:0] v);
    logic [31:0] d;
    logic a;
    reg_access(1'b0, TAG, 3'd0, v, d, a);
    check("thresh_wr_ack", 72'(a), 72'd1);
    m_thresh = v[15:0];
  endtask

  task automatic check_stats(input string phase);
    read_check({phase, "_tcp_pkts"},    3'd1, m_tcp);
    read_check({phase, "_other_pkts"},  3'd2, m_other);
    read_check({phase, "_last_win"},    3'd3, {16'h0, m_last});
    read_check({phase, "_min_win"},     3'd4, {16'h0, m_min});
    read_check({phase, "_low_win_cnt"}, 3'd5, m_low);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic        a;
    reset = 1'b1; in_wr = 1'b0; in_data = '0; in_ctrl = '0;
    reg_req_in = 1'b0; reg_ack_in = 1'b0; reg_rd_wr_L_in = 1'b0;
    reg_addr_in = '0; reg_data_in = '0; reg_src_in = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // reset state
    check("rst_out_wr", 72'(out_wr), 72'd0);
    check("rst_in_rdy", 72'(in_rdy), 72'd1);
    read_check("rst_thresh", 3'd0, 32'h0);
    check_stats("rst");

    // single TCP packet
    send_pkt(16'h0800, 4'd4, 4'd5, 8'd6, 16'h1234, 8, 8'h01);
    drain();
    check_stats("tcp1");

    // threshold: upper bits ignored, compare is inclusive
    write_thresh(32'hABCD_1000);
    read_check("thresh_rd", 3'd0, 32'h0000_1000);
    send_pkt(16'h0800, 4'd4, 4'd5, 8'd6, 16'h2000, 8, 8'h01);
    send_pkt(16'h0800, 4'd4, 4'd5, 8'd6, 16'h0800, 9, 8'h04);
    send_pkt(16'h0800, 4'd4, 4'd5, 8'd6, 16'h1000, 8, 8'h80);
    drain();
    check_stats("thresh");

    // non-TCP: ARP, UDP, IHL 6, version 6
    send_pkt(16'h0806, 4'd4, 4'd5, 8'd6,  16'h0001, 8, 8'h01);
    send_pkt(16'h0800, 4'd4, 4'd5, 8'h11, 16'h0002, 8, 8'h01);
    send_pkt(16'h0800, 4'd4, 4'd6, 8'd6,  16'h0003, 8, 8'h01);
    send_pkt(16'h0800, 4'd6, 4'd5, 8'd6,  16'h0004, 8, 8'h01);
    drain();
    check_stats("nontcp");

    // short packets and boundary lengths (EOP on word 5, 6, 7)
    send_pkt(16'h0800, 4'd4, 4'd5, 8'd6, 16'h0005, 5, 8'h20);
    send_pkt(16'h0800, 4'd4, 4'd5, 8'd6, 16'h0006, 6, 8'h20);
    send_pkt(16'h0800, 4'd4, 4'd5, 8'd6, 16'h0700, 7, 8'h02);
    send_pkt(16'h0800, 4'd4, 4'd5, 8'd6, 16'h4321, 8, 8'h01);
    drain();
    check_stats("short");

    // foreign tag passes through untouched
    reg_access(1'b1, 20'h00055, 3'd1, 32'hCAFE_F00D, d, a);
    check("pass_ack", 72'(a), 72'd0);
    check("pass_data", 72'(d), 72'h0000_0000_00CA_FEF0_0D);

    // FIFO fills with the sink stalled; then 100 packets under random out_rdy
    write_thresh({$urandom(), $urandom()} >> 32);
    rdy_mode = 1;
    repeat (2) @(posedge clk);
    #1;
    build_pkt(16'h0800, 4'd4, 4'd5, 8'd6, 16'($urandom()), 8, 8'h01);
    commit_pkt();
    drive_range(0, 3);
    check("in_rdy_nearly_full", 72'(in_rdy), 72'd0);
    rdy_mode = 2;
    drive_range(3, pkt.size());
    for (int k = 1; k < 100; k++) begin
      send_pkt(16'h0800, 4'd4, 4'd5, 8'd6, 16'($urandom()), $urandom_range(7, 12),
               8'(1 << $urandom_range(0, 7)));
    end
    rdy_mode = 0;
    drain();
    check_stats("random");

    // reset at word 4 of a TCP packet
    mon_en = 1'b0;
    build_pkt(16'h0800, 4'd4, 4'd5, 8'd6, 16'h0042, 8, 8'h01);
    drive_range(0, 5);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    model_reset();
    mon_en = 1'b1;
    check("rst2_out_wr", 72'(out_wr), 72'd0);
    read_check("rst2_thresh", 3'd0, 32'h0);
    check_stats("rst2");
    send_pkt(16'h0800, 4'd4, 4'd5, 8'd6, 16'h0BEE, 8, 8'h01);
    drain();
    check_stats("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
